// File: rtl/pcie_ltssm_link_trainer.sv
// Multi-lane Detect/Polling LTSSM front end: detect, TS1/TS2 polling, active-lane resolution.
// Optional macro LTSSM_POLL_COMPLIANCE_EN adds the Polling.Compliance state.
module pcie_ltssm_link_trainer #(
    parameter int NUM_LANES           = 4,
    parameter int QUIET_CYCLES        = 12000,
    parameter int POLL_TIMEOUT_CYCLES = 24000,
    parameter int TS1_TX_MIN          = 1024,
    parameter int TS_RX_REQ           = 8,
    parameter int TS2_TX_AFTER        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_LANES-1:0] rx_elec_idle_i,
    input  logic                 rx_det_done_i,
    input  logic [NUM_LANES-1:0] rx_det_i,
    input  logic [NUM_LANES-1:0] rx_ts1_i,
    input  logic [NUM_LANES-1:0] rx_ts2_i,
    input  logic                 tx_os_done_i,
    input  logic                 restart_i,
    output logic                 tx_det_req_o,
    output logic [1:0]           tx_os_type_o,
    output logic [NUM_LANES-1:0] tx_lane_en_o,
    output logic [NUM_LANES-1:0] active_lanes_o,
    output logic [2:0]           ltssm_state_o,
    output logic                 cfg_entry_o
);

    localparam int TMAX = (QUIET_CYCLES > POLL_TIMEOUT_CYCLES) ? QUIET_CYCLES : POLL_TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int XW   = $clog2(TS1_TX_MIN + 1);
    localparam int RW   = $clog2(TS_RX_REQ + 1);
    localparam int PW   = $clog2(TS2_TX_AFTER + 1);

    typedef enum logic [2:0] {
        S_DQUIET  = 3'd0,
        S_DACTIVE = 3'd1,
        S_PACTIVE = 3'd2,
        S_PCOMPL  = 3'd3,
        S_PCONFIG = 3'd4,
        S_CONFIG  = 3'd5
    } state_t;

    state_t               state_reg, state_next;
    logic [TW-1:0]        timer_reg;
    logic [XW-1:0]        txcnt_reg;
    logic [PW-1:0]        post_reg;
    logic                 ts2_seen_reg;
    logic [RW-1:0]        rxcnt_reg [NUM_LANES];
    logic [NUM_LANES-1:0] rx_full;
    logic [NUM_LANES-1:0] det_reg, det_next;
    logic [NUM_LANES-1:0] active_reg, active_next;

    logic [1:0]           os_type_next;
    logic [NUM_LANES-1:0] lane_en_next;
    logic                 det_req_next;
    logic                 cfg_entry_next;

    logic entering;
    logic quiet_done;
    logic poll_timeout;
    logic tx_full;
    logic post_full;

    assign entering     = (state_next != state_reg);
    assign quiet_done   = (timer_reg == TW'(QUIET_CYCLES - 1));
    assign poll_timeout = (timer_reg == TW'(POLL_TIMEOUT_CYCLES - 1));
    assign tx_full      = (txcnt_reg == XW'(TS1_TX_MIN));
    assign post_full    = (post_reg == PW'(TS2_TX_AFTER));

    // State, mask and registered-output storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= S_DQUIET;
            det_reg        <= '0;
            active_reg     <= '0;
            tx_det_req_o   <= 1'b0;
            tx_os_type_o   <= 2'b00;
            tx_lane_en_o   <= '0;
            cfg_entry_o    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            det_reg        <= det_next;
            active_reg     <= active_next;
            tx_det_req_o   <= det_req_next;
            tx_os_type_o   <= os_type_next;
            tx_lane_en_o   <= lane_en_next;
            cfg_entry_o    <= cfg_entry_next;
        end
    end

    assign ltssm_state_o  = state_reg;
    assign active_lanes_o = active_reg;

    always_comb begin
        state_next  = state_reg;
        det_next    = det_reg;
        active_next = active_reg;
        case (state_reg)
            S_DQUIET: begin
                if (quiet_done || !(&rx_elec_idle_i))
                    state_next = S_DACTIVE;
            end
            S_DACTIVE: begin
                if (rx_det_done_i) begin
                    if (rx_det_i == '0) begin
                        state_next = S_DQUIET;
                    end else begin
                        det_next   = rx_det_i;
                        state_next = S_PACTIVE;
                    end
                end
            end
            S_PACTIVE: begin
                // Full exit wins over a simultaneous timeout.
                if (tx_full && ((rx_full & det_reg) == det_reg)) begin
                    state_next  = S_PCONFIG;
                    active_next = det_reg;
                end else if (poll_timeout) begin
                    if (tx_full && |(rx_full & det_reg)) begin
                        state_next  = S_PCONFIG;
                        active_next = rx_full & det_reg;
                    end else begin
`ifdef LTSSM_POLL_COMPLIANCE_EN
                        state_next = S_PCOMPL;
`else
                        state_next = S_DQUIET;
`endif
                    end
                end
            end
`ifdef LTSSM_POLL_COMPLIANCE_EN
            S_PCOMPL: begin
                if (|(~rx_elec_idle_i & det_reg))
                    state_next = S_PACTIVE;
            end
`endif
            S_PCONFIG: begin
                if (|(rx_full & active_reg) && post_full)
                    state_next = S_CONFIG;
                else if (poll_timeout)
                    state_next = S_DQUIET;
            end
            S_CONFIG: begin
                if (restart_i)
                    state_next = S_DQUIET;
            end
            default: state_next = S_DQUIET;
        endcase
        // Any return to Detect discards both lane masks.
        if (state_next == S_DQUIET) begin
            det_next    = '0;
            active_next = '0;
        end
    end

    always_comb begin
        os_type_next   = 2'b00;
        lane_en_next   = '0;
        det_req_next   = (state_next == S_DACTIVE) && (state_reg != S_DACTIVE);
        cfg_entry_next = (state_next == S_CONFIG) && (state_reg != S_CONFIG);
        case (state_next)
            S_PACTIVE: begin
                os_type_next = 2'b01;
                lane_en_next = det_next;
            end
`ifdef LTSSM_POLL_COMPLIANCE_EN
            S_PCOMPL: begin
                os_type_next = 2'b11;
                lane_en_next = det_next;
            end
`endif
            S_PCONFIG: begin
                os_type_next = 2'b10;
                lane_en_next = active_next;
            end
            default: begin
                os_type_next = 2'b00;
                lane_en_next = '0;
            end
        endcase
    end

    // Shared timer and transmit-side counters restart on every state entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_reg    <= '0;
            txcnt_reg    <= '0;
            post_reg     <= '0;
            ts2_seen_reg <= 1'b0;
        end else if (entering) begin
            timer_reg    <= '0;
            txcnt_reg    <= '0;
            post_reg     <= '0;
            ts2_seen_reg <= 1'b0;
        end else begin
            if (timer_reg != TW'(TMAX))
                timer_reg <= timer_reg + TW'(1);
            if (state_reg == S_PACTIVE && tx_os_done_i && !tx_full)
                txcnt_reg <= txcnt_reg + XW'(1);
            if (state_reg == S_PCONFIG && |(rx_ts2_i & active_reg))
                ts2_seen_reg <= 1'b1;
            // Post-TS2 count begins the cycle after the first TS2 is seen.
            if (state_reg == S_PCONFIG && ts2_seen_reg && tx_os_done_i && !post_full)
                post_reg <= post_reg + PW'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign rx_full[gi] = (rxcnt_reg[gi] == RW'(TS_RX_REQ));

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rxcnt_reg[gi] <= '0;
            end else if (entering) begin
                rxcnt_reg[gi] <= '0;
            end else if (state_reg == S_PACTIVE) begin
                // Electrical idle breaks the consecutive-set run.
                if (rx_elec_idle_i[gi])
                    rxcnt_reg[gi] <= '0;
                else if ((rx_ts1_i[gi] || rx_ts2_i[gi]) && !rx_full[gi])
                    rxcnt_reg[gi] <= rxcnt_reg[gi] + RW'(1);
            end else if (state_reg == S_PCONFIG) begin
                if (rx_ts1_i[gi])
                    rxcnt_reg[gi] <= '0;
                else if (rx_ts2_i[gi] && !rx_full[gi])
                    rxcnt_reg[gi] <= rxcnt_reg[gi] + RW'(1);
            end
        end
    end

endmodule

// File: doc/pcie_ltssm_link_trainer.md
Name: pcie_ltssm_link_trainer

Overview:
Parametrised multi-lane successor to the Detect/Polling portion of the PCIe controller LTSSM. Runs Detect.Quiet/Detect.Active, receiver detection and Polling.Active/Polling.Configuration with real timers, per-lane TS1/TS2 counters and active-lane resolution. Hands off to the Configuration stage with a latched active-lane mask. Sits between the controller top level and the per-lane PHY TX/RX ordered-set logic.

Parameters:
NUM_LANES, 4, number of lanes (1..16)
QUIET_CYCLES, 12000, Detect.Quiet dwell in clk_i cycles
POLL_TIMEOUT_CYCLES, 24000, Polling.Active and Polling.Configuration timeout in cycles
TS1_TX_MIN, 1024, minimum TS1 sets transmitted before leaving Polling.Active
TS_RX_REQ, 8, consecutive TS1/TS2 sets required per lane
TS2_TX_AFTER, 16, TS2 sets transmitted after the first TS2 received

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
rx_elec_idle_i  in  NUM_LANES  per-lane receiver electrical idle, 1 = idle
rx_det_done_i  in  1  one-cycle pulse: receiver-detect result valid
rx_det_i  in  NUM_LANES  receiver-detect result, sampled when rx_det_done_i=1
rx_ts1_i  in  NUM_LANES  one-cycle pulse per TS1 received on a lane
rx_ts2_i  in  NUM_LANES  one-cycle pulse per TS2 received on a lane
tx_os_done_i  in  1  one-cycle pulse per ordered set transmitted (all lanes in lockstep)
restart_i  in  1  pulse: leave CONFIG and retrain
tx_det_req_o  out  1  one-cycle receiver-detect request
tx_os_type_o  out  2  00 electrical idle, 01 TS1, 10 TS2, 11 compliance pattern
tx_lane_en_o  out  NUM_LANES  lanes currently transmitting
active_lanes_o  out  NUM_LANES  latched trained-lane mask
ltssm_state_o  out  3  0 DQUIET, 1 DACTIVE, 2 PACTIVE, 3 PCOMPL, 4 PCONFIG, 5 CONFIG
cfg_entry_o  out  1  one-cycle pulse on CONFIG entry

Behaviour:
- Reset: rst_i is asynchronous, active-high. Clock is clk_i. All outputs 0 in reset; state DQUIET; timer, counters and lane masks cleared.
- Outputs are registered. State changes take effect on the clock edge after the exit condition is true.
- One shared timer, width $clog2(max(QUIET_CYCLES,POLL_TIMEOUT_CYCLES)+1). Cleared on every state entry, saturates at max.
- DQUIET: tx_os_type_o=00, tx_lane_en_o=0.
  - Go to DACTIVE when timer==QUIET_CYCLES-1, or when any lane has rx_elec_idle_i=0.
- DACTIVE: tx_det_req_o=1 in the first cycle only, then wait for rx_det_done_i.
  - If rx_det_i==0: go to DQUIET.
  - Otherwise: detected mask <= rx_det_i, go to PACTIVE.
  - No timeout in this state.
- PACTIVE: tx_os_type_o=01, tx_lane_en_o=detected mask.
  - tx counter increments on tx_os_done_i, saturating at TS1_TX_MIN.
  - Per-lane rx counter increments on rx_ts1_i|rx_ts2_i. A simultaneous TS1 and TS2 counts once. Saturates at TS_RX_REQ.
  - A lane whose rx_elec_idle_i=1 has its counter cleared (the consecutive rule).
  - Exit to PCONFIG when txcnt==TS1_TX_MIN and every detected lane has rxcnt==TS_RX_REQ. active_lanes_o <= detected mask.
  - On timeout (timer==POLL_TIMEOUT_CYCLES-1):
    - If txcnt==TS1_TX_MIN and at least one lane has reached TS_RX_REQ: go to PCONFIG, active_lanes_o <= the lanes that reached it.
    - Otherwise: go to DQUIET (see optional feature).
  - If the full-exit and timeout conditions are true in the same cycle, the full-exit takes priority.
- PCONFIG: tx_os_type_o=10, tx_lane_en_o=active_lanes_o. Per-lane counters and txcnt cleared on entry.
  - Per-lane counters count rx_ts2_i only. rx_ts1_i on a lane clears that lane's counter.
  - The post-TS2 tx counter starts after the first rx_ts2_i on any active lane. It counts tx_os_done_i and saturates at TS2_TX_AFTER.
  - Exit to CONFIG when any active lane has rxcnt==TS_RX_REQ and the post-TS2 counter==TS2_TX_AFTER.
  - Timeout: go to DQUIET and clear active_lanes_o.
- CONFIG: tx_os_type_o=00. cfg_entry_o=1 in the first cycle only. active_lanes_o held.
  - On restart_i: go to DQUIET and clear masks.
  - restart_i is ignored in all other states.
- Reset asserted mid-training returns to DQUIET immediately, with masks cleared.

Optional Feature:
Macro LTSSM_POLL_COMPLIANCE_EN.
- Defined: a PACTIVE timeout with no qualifying lane goes to PCOMPL. In PCOMPL: tx_os_type_o=11, tx_lane_en_o=detected mask. Exit to PACTIVE when any detected lane has rx_elec_idle_i=0; the timer restarts on that entry. PCOMPL has no timeout.
- Not defined: that case goes to DQUIET. Encoding 3 is never produced, and the PCOMPL logic is absent.

Test Plan:
Use NUM_LANES=4, QUIET_CYCLES=16, POLL_TIMEOUT_CYCLES=200, TS1_TX_MIN=8, TS_RX_REQ=8, TS2_TX_AFTER=4.
1. All rx_elec_idle_i=1 from reset -> DQUIET for 16 cycles, then DACTIVE with a single tx_det_req_o pulse. rx_det_done_i with rx_det_i=0 -> DQUIET.
2. rx_det_i=4'b1111; 8 tx_os_done_i pulses; 8 TS1 on every lane -> PCONFIG, active_lanes_o=4'b1111, tx_os_type_o=10. Then 8 TS2 per lane plus 4 tx_os_done_i after the first TS2 -> CONFIG, cfg_entry_o pulses exactly once.
3. rx_det_i=4'b1111; lanes 0–1 receive 8 TS1, lanes 2–3 receive none; txcnt saturated -> at timer 199, PCONFIG with active_lanes_o=4'b0011.
4. In PACTIVE, lane 0 receives 5 TS1, then rx_elec_idle_i[0]=1 for one cycle, then 3 TS1 -> lane 0 counter is 3 and no exit occurs.
5. PCONFIG with no TS2 received for 200 cycles -> DQUIET, active_lanes_o=0. Assert rst_i mid-PACTIVE -> outputs 0 asynchronously.
6. With the macro defined: PACTIVE timeout with zero TS1 received -> PCOMPL, tx_os_type_o=11. rx_elec_idle_i[2]=0 -> PACTIVE. Without the macro, the same stimulus -> DQUIET.
